reg_write_arbiter: RTL and testbench
====================================

// Module: reg_write_arbiter
// PURPOSE
// Shares the single write path into the CPU's bank of 11-bit registers between several requesters.
// Requesters include fetch, ALU writeback and load.
// Round-robin arbitration; drives the shared data bus and per-register enable/clear lines.
// Sits between the control unit and the register bank; only block allowed to drive register enables.
// PARAMETERS
// NUM_REQ   3   number of requesters (2..8)
// DATA_W    11  register/data width
// NUM_REGS  8   registers in the bank
// ADDR_W    3   register address width; 2**ADDR_W >= NUM_REGS
// PORTS
// CLK         in   1                 rising-edge clock
// clear_n     in   1                 asynchronous active-low reset
// req         in   NUM_REQ           write request, one bit per requester; held until granted
// req_addr    in   NUM_REQ*ADDR_W    target register per requester; requester i in slice [i*ADDR_W +: ADDR_W]
// req_data    in   NUM_REQ*DATA_W    write data per requester; requester i in slice [i*DATA_W +: DATA_W]
// clear_all   in   1                 single-cycle pulse: clear every register in the bank
// gnt         out  NUM_REQ           one-hot single-cycle grant; write happens in that cycle
// reg_in      out  DATA_W            shared data bus to all registers
// reg_enable  out  NUM_REGS          one-hot write enable to register bank
// reg_clear   out  NUM_REGS          clear lines to register bank (all bits equal)
// wr_err      out  1                 pulses with gnt when granted address >= NUM_REGS
// busy        out  1                 high whenever state != IDLE
// BEHAVIOUR
// - All outputs registered. Reset (clear_n=0, any time, async):
//   - state=IDLE; gnt, reg_in, reg_enable, reg_clear, wr_err, busy all 0.
//   - last-winner pointer = NUM_REQ-1, so requester 0 wins first.
//   - Reset mid-WRITE aborts it: enables drop immediately, no grant is reported.
// - FSM states IDLE, WRITE, CLEAR:
//   - IDLE -> CLEAR if clear_all pending (priority over req).
//   - IDLE -> WRITE if any req.
//   - Otherwise stay IDLE.
//   - WRITE -> IDLE and CLEAR -> IDLE, each unconditionally after one cycle.
// - WRITE cycle, winner w:
//   - gnt[w]=1; reg_in=req_data[w]; reg_enable=onehot(req_addr[w]).
//   - The bank captures at the edge ending WRITE. Latency: req seen in IDLE -> data in register 2 edges later.
// - Requester handshake: drop req (or present new addr/data) in the cycle after gnt.
//   - The mandatory IDLE cycle between writes prevents a double write.
//   - Peak throughput: one write per 2 cycles.
// - Round-robin: winner is the first requesting index after last-winner, wrapping NUM_REQ-1 -> 0.
//   - Pointer updates only on a grant. Starvation bound: NUM_REQ grants.
// - Address >= NUM_REGS: grant still issued (requester unblocked); reg_enable=0; wr_err=1 for that cycle.
// - clear_all is latched into a pending flag.
//   - Pulse arriving during WRITE: the write completes, then CLEAR runs next.
//   - Multiple pulses before service collapse into one CLEAR.
//   - CLEAR cycle: reg_clear = all ones; reg_enable=0; gnt=0; flag cleared.
// - Outside WRITE: reg_in holds its last value; reg_enable and gnt are 0.
// CONFIGURATION
// - ARB_FIXED_PRIORITY_EN defined: fixed priority, lowest index wins; pointer logic removed; lower requesters can starve higher ones.
// - Undefined (default): round-robin as above.
// TESTING
// - Reset, then req=3'b001, addr0=2, data0=11'h555 -> gnt=001 and reg_enable=8'h04 and reg_in=11'h555 for exactly 1 cycle, busy=1 that cycle.
// - req=3'b111 held, each requester dropping after its gnt -> grants in order 001,010,100 on alternate cycles; no gnt repeats while req held.
// - req=3'b101 held continuously (re-requesting) over 6 grants -> alternates 001,100,001,...; never two back-to-back WRITE cycles.
// - clear_all pulse during a WRITE with req=3'b010 pending -> WRITE completes, next active cycle reg_clear=8'hFF, then requester 1 granted.
// - req addr=7 with NUM_REGS=6 -> gnt pulses, wr_err=1, reg_enable=0.
// - clear_n low mid-WRITE -> all outputs 0 immediately; after release first grant goes to requester 0.
// - With ARB_FIXED_PRIORITY_EN, req=3'b011 held -> requester 0 granted every WRITE; requester 1 never granted.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Arbitrates several requesters onto the single write path of the register bank.
// Define ARB_FIXED_PRIORITY_EN for fixed lowest-index-wins priority; round-robin otherwise.
module reg_write_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int DATA_W   = 11,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic                      CLK,
    input  logic                      clear_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      clear_all,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [DATA_W-1:0]         reg_in,
    output logic [NUM_REGS-1:0]       reg_enable,
    output logic [NUM_REGS-1:0]       reg_clear,
    output logic                      wr_err,
    output logic                      busy
);

    localparam int          PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NREQ_U  = NUM_REQ;
    localparam int unsigned NREGS_U = NUM_REGS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic                clr_pend, clr_pend_nxt;
    logic                found;
    logic [NUM_REQ-1:0]  win_oh;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;
    logic [NUM_REGS-1:0] en_dec;
    logic                addr_bad;
    logic                grant_evt;

    logic [NUM_REQ-1:0]  gnt_nxt;
    logic [DATA_W-1:0]   reg_in_nxt;
    logic [NUM_REGS-1:0] reg_enable_nxt;
    logic [NUM_REGS-1:0] reg_clear_nxt;
    logic                wr_err_nxt;

`ifndef ARB_FIXED_PRIORITY_EN
    logic [PTR_W-1:0]    last_ptr;
    logic [PTR_W-1:0]    win_idx;
`endif

    // Round-robin: first pass looks above the last winner, second pass wraps from 0.
    always_comb begin
        found    = 1'b0;
        win_oh   = '0;
        win_addr = '0;
        win_data = '0;
`ifndef ARB_FIXED_PRIORITY_EN
        win_idx  = '0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            if (!found && req[i] && (i > 32'(last_ptr))) begin
                found     = 1'b1;
                win_oh[i] = 1'b1;
                win_idx   = PTR_W'(i);
                win_addr  = req_addr[i*ADDR_W +: ADDR_W];
                win_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
`endif
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            if (!found && req[i]) begin
                found     = 1'b1;
                win_oh[i] = 1'b1;
`ifndef ARB_FIXED_PRIORITY_EN
                win_idx   = PTR_W'(i);
`endif
                win_addr  = req_addr[i*ADDR_W +: ADDR_W];
                win_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        en_dec = '0;
        for (int unsigned r = 0; r < NREGS_U; r++) begin
            en_dec[r] = (32'(win_addr) == r);
        end
        addr_bad = (32'(win_addr) >= NREGS_U);
    end

    always_comb begin
        state_nxt      = state;
        clr_pend_nxt   = clr_pend | clear_all;
        gnt_nxt        = '0;
        reg_in_nxt     = reg_in;
        reg_enable_nxt = '0;
        reg_clear_nxt  = '0;
        wr_err_nxt     = 1'b0;
        grant_evt      = 1'b0;
        case (state)
            IDLE: begin
                if (clr_pend || clear_all) begin
                    state_nxt     = CLEAR;
                    clr_pend_nxt  = 1'b0;
                    reg_clear_nxt = '1;
                end else if (found) begin
                    state_nxt      = WRITE;
                    grant_evt      = 1'b1;
                    gnt_nxt        = win_oh;
                    reg_in_nxt     = win_data;
                    reg_enable_nxt = addr_bad ? '0 : en_dec;
                    wr_err_nxt     = addr_bad;
                end
            end
            WRITE:   state_nxt = IDLE;
            CLEAR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge clear_n) begin
        if (!clear_n) begin
            state      <= IDLE;
            clr_pend   <= 1'b0;
            gnt        <= '0;
            reg_in     <= '0;
            reg_enable <= '0;
            reg_clear  <= '0;
            wr_err     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            clr_pend   <= clr_pend_nxt;
            gnt        <= gnt_nxt;
            reg_in     <= reg_in_nxt;
            reg_enable <= reg_enable_nxt;
            reg_clear  <= reg_clear_nxt;
            wr_err     <= wr_err_nxt;
            busy       <= (state_nxt != IDLE);
        end
    end

`ifndef ARB_FIXED_PRIORITY_EN
    always_ff @(posedge CLK or negedge clear_n) begin
        if (!clear_n) begin
            last_ptr <= PTR_W'(NUM_REQ - 1);
        end else if (grant_evt) begin
            last_ptr <= win_idx;
        end
    end
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: a second instance with six registers covers out-of-range addresses.
module tb_reg_write_arbiter;

    logic        CLK = 1'b0;
    logic        clear_n = 1'b1;
    logic [2:0]  req = '0;
    logic [8:0]  req_addr = '0;
    logic [32:0] req_data = '0;
    logic        clear_all = 1'b0;

    logic [2:0]  gnt;
    logic [10:0] reg_in;
    logic [7:0]  reg_enable;
    logic [7:0]  reg_clear;
    logic        wr_err;
    logic        busy;

    logic [2:0]  gnt6;
    logic [10:0] reg_in6;
    logic [5:0]  reg_enable6;
    logic [5:0]  reg_clear6;
    logic        wr_err6;
    logic        busy6;

    typedef struct {
        logic [2:0]  g;
        logic [10:0] data;
        logic [7:0]  en;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          last_w = 2;
    logic [10:0] last_data = '0;

    always #5 CLK = ~CLK;

    reg_write_arbiter #(.NUM_REQ(3), .DATA_W(11), .NUM_REGS(8), .ADDR_W(3)) dut (
        .CLK(CLK), .clear_n(clear_n), .req(req), .req_addr(req_addr), .req_data(req_data),
        .clear_all(clear_all), .gnt(gnt), .reg_in(reg_in), .reg_enable(reg_enable),
        .reg_clear(reg_clear), .wr_err(wr_err), .busy(busy)
    );

    reg_write_arbiter #(.NUM_REQ(3), .DATA_W(11), .NUM_REGS(6), .ADDR_W(3)) dut6 (
        .CLK(CLK), .clear_n(clear_n), .req(req), .req_addr(req_addr), .req_data(req_data),
        .clear_all(clear_all), .gnt(gnt6), .reg_in(reg_in6), .reg_enable(reg_enable6),
        .reg_clear(reg_clear6), .wr_err(wr_err6), .busy(busy6)
    );

    function automatic int model_next(input logic [2:0] p, input int last);
        int idx;
`ifdef ARB_FIXED_PRIORITY_EN
        for (int i = 0; i < 3; i++) begin
            if (p[i]) return i;
        end
`else
        for (int k = 1; k <= 3; k++) begin
            idx = (last + k) % 3;
            if (p[idx]) return idx;
        end
`endif
        return 0;
    endfunction

    task automatic set_fields(input int i, input logic [2:0] a, input logic [10:0] d);
        req_addr[i*3 +: 3]  = a;
        req_data[i*11 +: 11] = d;
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (gnt !== 3'b000) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        clear_n   = 1'b1;
        req       = '0;
        clear_all = 1'b0;
        #1;
        clear_n = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if ({gnt, reg_enable, reg_clear, wr_err, busy} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: gnt=%b en=%h clr=%h err=%b busy=%b, required all 0",
                     gnt, reg_enable, reg_clear, wr_err, busy);
        end
        checks++;
        if (reg_in !== 11'h000) begin
            errors++;
            $display("FAIL reset_reg_in: got %h, required 000", reg_in);
        end
        checks++;
        if ({gnt6, reg_enable6, reg_clear6, wr_err6, busy6} !== '0) begin
            errors++;
            $display("FAIL reset_dut6: gnt=%b en=%h busy=%b, required all 0", gnt6, reg_enable6, busy6);
        end
        clear_n   = 1'b1;
        last_w    = 2;
        last_data = '0;
        sbq.delete();
    endtask

    // Expected grants come from the model at stimulus time; the DUT's grants pop them.
    task automatic run_sched(input logic [2:0] r, input logic [2:0] persist, input int n, input string name);
        logic [2:0] pending;
        exp_t       e;
        int         w;
        bit         prev_g;
        int         budget;
        pending = r;
        for (int k = 0; k < n; k++) begin
            if (pending == 3'b000) break;
            w      = model_next(pending, last_w);
            e.g    = 3'b001 << w;
            e.data = req_data[w*11 +: 11];
            e.en   = 8'(1) << req_addr[w*3 +: 3];
            sbq.push_back(e);
            last_w = w;
            if (!persist[w]) pending[w] = 1'b0;
        end
        req    = r;
        prev_g = 1'b0;
        budget = 4 * n + 8;
        while (sbq.size() > 0 && budget > 0) begin
            @(negedge CLK);
            budget--;
            if (gnt !== 3'b000) begin
                e = sbq.pop_front();
                checks++;
                if (gnt !== e.g || reg_in !== e.data || reg_enable !== e.en || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_grant: gnt=%b data=%h en=%h busy=%b, required gnt=%b data=%h en=%h busy=1",
                             name, gnt, reg_in, reg_enable, busy, e.g, e.data, e.en);
                end
                checks++;
                if (prev_g) begin
                    errors++;
                    $display("FAIL %s_back_to_back: gnt=%b in consecutive cycles, required an idle cycle", name, gnt);
                end
                last_data = e.data;
                req = req & ~(gnt & ~persist);
                if (sbq.size() == 0) req = '0;
                prev_g = 1'b1;
            end else begin
                checks++;
                if (reg_in !== last_data || reg_enable !== 8'h00) begin
                    errors++;
                    $display("FAIL %s_hold: reg_in=%h en=%h, required reg_in=%h en=00",
                             name, reg_in, reg_enable, last_data);
                end
                prev_g = 1'b0;
            end
        end
        if (sbq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d grants outstanding, required 0", name, sbq.size());
            sbq.delete();
        end
        req = '0;
        repeat (3) begin
            @(negedge CLK);
            checks++;
            if (gnt !== 3'b000) begin
                errors++;
                $display("FAIL %s_trailing: gnt=%b, required 000", name, gnt);
            end
        end
    endtask

    task automatic test_single();
        set_fields(0, 3'd2, 11'h555);
        run_sched(3'b001, 3'b000, 1, "single");
    endtask

    task automatic test_round_robin();
        set_fields(0, 3'd1, 11'h111);
        set_fields(1, 3'd5, 11'h2AA);
        set_fields(2, 3'd7, 11'h7FF);
        run_sched(3'b111, 3'b000, 3, "round_robin");
    endtask

    task automatic test_back_to_back();
        set_fields(0, 3'd0, 11'h0C3);
        set_fields(2, 3'd6, 11'h63C);
        run_sched(3'b101, 3'b101, 6, "back_to_back");
    endtask

    task automatic test_clear_during_write();
        bit ok;
        set_fields(0, 3'd3, 11'h0AB);
        set_fields(1, 3'd6, 11'h155);
        req = 3'b001;
        wait_gnt(ok);
        checks++;
        if (!ok || gnt !== 3'b001) begin
            errors++;
            $display("FAIL clr_first_write: gnt=%b, required 001", gnt);
        end
        last_w    = 0;
        last_data = 11'h0AB;
        req       = 3'b010;
        clear_all = 1'b1;
        @(negedge CLK);
        checks++;
        if (gnt !== 3'b000 || reg_clear !== 8'h00 || busy !== 1'b0 || reg_in !== 11'h0AB) begin
            errors++;
            $display("FAIL clr_idle1: gnt=%b clr=%h busy=%b reg_in=%h, required 000 00 0 0ab",
                     gnt, reg_clear, busy, reg_in);
        end
        @(negedge CLK);
        clear_all = 1'b0;
        checks++;
        if (reg_clear !== 8'hFF || reg_enable !== 8'h00 || gnt !== 3'b000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL clr_cycle: clr=%h en=%h gnt=%b busy=%b, required ff 00 000 1",
                     reg_clear, reg_enable, gnt, busy);
        end
        checks++;
        if (reg_clear6 !== 6'h3F) begin
            errors++;
            $display("FAIL clr_cycle6: clr=%h, required 3f", reg_clear6);
        end
        @(negedge CLK);
        checks++;
        if (reg_clear !== 8'h00 || gnt !== 3'b000) begin
            errors++;
            $display("FAIL clr_single: clr=%h gnt=%b, required 00 000", reg_clear, gnt);
        end
        @(negedge CLK);
        checks++;
        if (gnt !== 3'b010 || reg_in !== 11'h155 || reg_enable !== 8'h40) begin
            errors++;
            $display("FAIL clr_then_req1: gnt=%b data=%h en=%h, required 010 155 40", gnt, reg_in, reg_enable);
        end
        last_w    = 1;
        last_data = 11'h155;
        req       = '0;
        @(negedge CLK);
    endtask

    task automatic test_addr_error();
        bit ok;
        set_fields(0, 3'd7, 11'h321);
        req = 3'b001;
        wait_gnt(ok);
        checks++;
        if (!ok || gnt6 !== 3'b001 || wr_err6 !== 1'b1 || reg_enable6 !== 6'h00) begin
            errors++;
            $display("FAIL addr_err6: gnt=%b err=%b en=%h, required 001 1 00", gnt6, wr_err6, reg_enable6);
        end
        checks++;
        if (gnt !== 3'b001 || wr_err !== 1'b0 || reg_enable !== 8'h80) begin
            errors++;
            $display("FAIL addr7_dut8: gnt=%b err=%b en=%h, required 001 0 80", gnt, wr_err, reg_enable);
        end
        last_w    = 0;
        last_data = 11'h321;
        req       = '0;
        @(negedge CLK);
        checks++;
        if (wr_err6 !== 1'b0 || gnt6 !== 3'b000) begin
            errors++;
            $display("FAIL addr_err_pulse: err=%b gnt=%b, required 0 000", wr_err6, gnt6);
        end
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        set_fields(1, 3'd4, 11'h0F0);
        req = 3'b010;
        wait_gnt(ok);
        checks++;
        if (!ok || gnt !== 3'b010) begin
            errors++;
            $display("FAIL rst_pre_write: gnt=%b, required 010", gnt);
        end
        clear_n = 1'b0;
        #1;
        checks++;
        if ({gnt, reg_enable, reg_clear, wr_err, busy} !== '0 || reg_in !== 11'h000) begin
            errors++;
            $display("FAIL rst_mid_write: gnt=%b en=%h busy=%b reg_in=%h, required all 0",
                     gnt, reg_enable, busy, reg_in);
        end
        set_fields(0, 3'd1, 11'h3C3);
        req = 3'b011;
        @(negedge CLK);
        clear_n   = 1'b1;
        last_w    = 2;
        last_data = '0;
        run_sched(3'b011, 3'b000, 2, "after_reset");
    endtask

    task automatic test_fixed_priority();
        set_fields(0, 3'd2, 11'h00F);
        set_fields(1, 3'd3, 11'h0F0);
        run_sched(3'b011, 3'b011, 4, "held_011");
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset();
        test_round_robin();
        test_back_to_back();
        test_clear_during_write();
        test_addr_error();
        test_reset_mid_write();
        test_fixed_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
